// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - input field stream and output word stream of the instruction encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_func;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_word;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_func, in_imm, in_target,
        output out_ready,
        input  in_ready, out_valid, out_addr, out_word
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_func, in_imm, in_target,
        input  out_ready,
        output in_ready, out_valid, out_addr, out_word
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes decoded MIPS fields into machine words with sequential addresses
module instr_encoder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    instr_encoder_if.slave       bus,
    output logic [16:0]          count,
    output logic                 err,
    output logic                 done
);
    localparam logic [16:0] L_DEPTH = 17'(DEPTH);

    // Two-entry buffer kept as a shift pair: entry 0 is always the head.
    logic [31:0] r_word0, r_word1;
    logic [31:0] r_addr0, r_addr1;
    logic [1:0]  r_occ;
    logic [16:0] r_count;
    logic        r_err;

    logic [31:0] w_enc;
    logic        w_supported;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_addr;

    always_comb begin
        w_supported = 1'b1;
        w_enc       = '0;
        case (bus.in_kind)
            4'd0:  w_enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_func};
            4'd1:  w_enc = {6'b000000, bus.in_rs, 15'b0, 6'b001000};
            4'd2:  w_enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd3:  w_enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd4:  w_enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd5:  w_enc = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6:  w_enc = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7:  w_enc = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8:  w_enc = {6'b001010, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:  w_enc = {6'b000010, bus.in_target};
            4'd10: w_enc = {6'b000011, bus.in_target};
            4'd11: w_enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd12: w_enc = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            default: w_supported = 1'b0;
        endcase
    end

    // in_ready is held low during reset and never looks at out_ready.
    assign bus.in_ready  = rst_n & ~clear & (r_count < L_DEPTH) & (r_occ != 2'd2);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_push        = w_accept & w_supported;
    assign w_pop         = (r_occ != 2'd0) & bus.out_ready;
    assign w_addr        = BASE_ADDR + {13'b0, r_count, 2'b00};

    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_word  = r_word0;
    assign bus.out_addr  = r_addr0;
    assign count         = r_count;
    assign err           = r_err;
    assign done          = (r_count == L_DEPTH) & (r_occ == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word0 <= '0;
            r_word1 <= '0;
            r_addr0 <= BASE_ADDR;
            r_addr1 <= BASE_ADDR;
            r_occ   <= 2'd0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_word0 <= '0;
            r_word1 <= '0;
            r_addr0 <= BASE_ADDR;
            r_addr1 <= BASE_ADDR;
            r_occ   <= 2'd0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept && !w_supported)
                r_err <= 1'b1;
            if (w_push)
                r_count <= r_count + 17'd1;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_word0 <= w_enc;
                        r_addr0 <= w_addr;
                    end else begin
                        r_word1 <= w_enc;
                        r_addr1 <= w_addr;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_word0 <= r_word1;
                    r_addr0 <= r_addr1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Push while popping: new word goes behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_word0 <= w_enc;
                        r_addr0 <= w_addr;
                    end else begin
                        r_word0 <= r_word1;
                        r_addr0 <= r_addr1;
                        r_word1 <= w_enc;
                        r_addr1 <= w_addr;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with randomized and directed stimulus
module tb_instr_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear_a, clear_b;
    logic [3:0]  f_kind;
    logic [4:0]  f_rs, f_rt, f_rd, f_sh;
    logic [5:0]  f_func;
    logic [15:0] f_imm;
    logic [25:0] f_tgt;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    int          rmode [2];

    logic [16:0] cnt_a, cnt_b;
    logic        err_a, err_b, done_a, done_b;

    instr_encoder_if bus_a ();
    instr_encoder_if bus_b ();

    assign bus_a.in_valid = iv[0];    assign bus_b.in_valid = iv[1];
    assign bus_a.out_ready = ordy[0]; assign bus_b.out_ready = ordy[1];
    assign bus_a.in_kind = f_kind;    assign bus_b.in_kind = f_kind;
    assign bus_a.in_rs = f_rs;        assign bus_b.in_rs = f_rs;
    assign bus_a.in_rt = f_rt;        assign bus_b.in_rt = f_rt;
    assign bus_a.in_rd = f_rd;        assign bus_b.in_rd = f_rd;
    assign bus_a.in_shamt = f_sh;     assign bus_b.in_shamt = f_sh;
    assign bus_a.in_func = f_func;    assign bus_b.in_func = f_func;
    assign bus_a.in_imm = f_imm;      assign bus_b.in_imm = f_imm;
    assign bus_a.in_target = f_tgt;   assign bus_b.in_target = f_tgt;

    instr_encoder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .bus(bus_a),
        .count(cnt_a), .err(err_a), .done(done_a));

    instr_encoder #(.DEPTH(2), .BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .bus(bus_b),
        .count(cnt_b), .err(err_b), .done(done_b));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected buffer contents as {addr, word}, plus count and err.
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] popped_a [$];
    int          mcount [2];
    bit          merr [2];
    int          mdepth [2] = '{256, 2};
    logic [31:0] mbase [2] = '{32'h0000_0000, 32'hFFFF_FFFC};

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [63:0] q_front(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(input int d);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction

    function automatic void q_push(input int d, input logic [63:0] v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic void model_reset(input int d);
        if (d == 0) q0.delete(); else q1.delete();
        mcount[d] = 0;
        merr[d]   = 1'b0;
    endfunction

    function automatic int op_of(input logic [3:0] k);
        case (k)
            4'd2: return 35;  4'd3: return 43;  4'd4: return 8;   4'd5: return 12;
            4'd6: return 13;  4'd7: return 14;  4'd8: return 10;  4'd9: return 2;
            4'd10: return 3;  4'd11: return 4;  4'd12: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [3:0] k);
        longint w;
        if (k == 4'd0)
            w = longint'(f_rs) * (2**21) + longint'(f_rt) * (2**16) + longint'(f_rd) * (2**11)
              + longint'(f_sh) * (2**6) + longint'(f_func);
        else if (k == 4'd1)
            w = longint'(f_rs) * (2**21) + 8;
        else if (k == 4'd9 || k == 4'd10)
            w = longint'(op_of(k)) * (2**26) + longint'(f_tgt);
        else
            w = longint'(op_of(k)) * (2**26) + longint'(f_rs) * (2**21)
              + longint'(f_rt) * (2**16) + longint'(f_imm);
        return w[31:0];
    endfunction

    task automatic model_step(input int d, input logic clr, input logic ivd, input logic ir,
                              input logic ov, input logic ordd, input logic [31:0] ow,
                              input logic [31:0] oa, input logic [16:0] cnt, input logic er,
                              input logic dn);
        bit exp_ready;
        logic [31:0] a;
        exp_ready = !clr && (mcount[d] < mdepth[d]) && (q_size(d) < 2);
        chk($sformatf("in_ready%0d", d), 64'(ir), 64'(exp_ready));
        chk($sformatf("out_valid%0d", d), 64'(ov), 64'(q_size(d) != 0));
        if (q_size(d) != 0) chk($sformatf("out_addr_word%0d", d), {oa, ow}, q_front(d));
        chk($sformatf("count%0d", d), 64'(cnt), 64'(mcount[d]));
        chk($sformatf("err%0d", d), 64'(er), 64'(merr[d]));
        chk($sformatf("done%0d", d), 64'(dn), 64'(mcount[d] == mdepth[d] && q_size(d) == 0));
        if (clr) begin
            model_reset(d);
            return;
        end
        if (ov && ordd && q_size(d) != 0) begin
            q_pop(d);
            if (d == 0) popped_a.push_back({oa, ow});
        end
        if (ivd && exp_ready) begin
            if (f_kind <= 4'd12) begin
                a = mbase[d] + 32'(4 * mcount[d]);
                q_push(d, {a, ref_word(f_kind)});
                mcount[d]++;
            end else begin
                merr[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            model_step(0, clear_a, iv[0], bus_a.in_ready, bus_a.out_valid, ordy[0],
                       bus_a.out_word, bus_a.out_addr, cnt_a, err_a, done_a);
            model_step(1, clear_b, iv[1], bus_b.in_ready, bus_b.out_valid, ordy[1],
                       bus_b.out_word, bus_b.out_addr, cnt_b, err_b, done_b);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            ordy[d] = (rmode[d] == 2) ? 1'($urandom_range(0, 1)) : (rmode[d] == 1);
    end

    task automatic send(input int d, input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt);
        bit ok = 1'b0;
        f_kind = k; f_rs = rs; f_rt = rt; f_rd = rd; f_sh = sh;
        f_func = fn; f_imm = imm; f_tgt = tgt;
        iv[d] = 1'b1;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            ok = (d == 0) ? bus_a.in_ready : bus_b.in_ready;
        end
        @(posedge clk); #1;
        iv[d] = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand(input int d, input logic [3:0] k);
        send(d, k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             16'($urandom), 26'($urandom));
    endtask

    task automatic wait_drain(input int d);
        for (int c = 0; c < 300 && q_size(d) != 0; c++) @(negedge clk);
        if (q_size(d) != 0) chk("drain_timeout", 64'(q_size(d)), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear(input int d);
        if (d == 0) clear_a = 1'b1; else clear_b = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0; clear_b = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear_a = 1'b0; clear_b = 1'b0; iv = '0;
        rmode = '{1, 1};
        f_kind = '0; f_rs = '0; f_rt = '0; f_rd = '0; f_sh = '0; f_func = '0; f_imm = '0; f_tgt = '0;
        model_reset(0); model_reset(1);
        #13;
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_out_word", 64'(bus_a.out_word), 64'd0);
        chk("rst_addr_b", 64'(bus_b.out_addr), 64'hFFFF_FFFC);
        chk("rst_in_ready", 64'({bus_a.in_ready, bus_b.in_ready}), 64'd0);
        chk("rst_count_err_done", 64'({cnt_a, err_a, done_a, done_b}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(0, 4'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        chk("addi_valid", 64'(bus_a.out_valid), 64'd1);
        chk("addi_word_addr", {bus_a.out_addr, bus_a.out_word}, {32'h0, 32'h2008_0005});
        chk("addi_count", 64'(cnt_a), 64'd1);
        wait_drain(0);

        pulse_clear(0);
        popped_a.delete();
        send(0, 4'd2, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        send(0, 4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'b100000, 16'd0, 26'd0);
        send(0, 4'd1, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        send(0, 4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000);
        wait_drain(0);
        chk("b2b_n", 64'(popped_a.size()), 64'd4);
        if (popped_a.size() == 4) begin
            chk("b2b_lw", popped_a[0], {32'h0, 32'h8FA9_0004});
            chk("b2b_r", popped_a[1], {32'h4, 32'h0109_5020});
            chk("b2b_jr", popped_a[2], {32'h8, 32'h03E0_0008});
            chk("b2b_j", popped_a[3], {32'hC, 32'h0810_0000});
        end

        pulse_clear(0);
        popped_a.delete();
        rmode[0] = 0;
        send(0, 4'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        send(0, 4'd4, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'd6, 26'd0);
        fork
            send(0, 4'd4, 5'd0, 5'd10, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
                    chk("bp_hold", 64'(bus_a.out_word), 64'h2008_0005);
                end
                rmode[0] = 1;
            end
        join
        wait_drain(0);
        chk("bp_n", 64'(popped_a.size()), 64'd3);
        if (popped_a.size() == 3)
            chk("bp_third", popped_a[2], {32'h8, 32'h200A_0007});

        pulse_clear(0);
        popped_a.delete();
        send(0, 4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00AA, 26'd0);
        send(0, 4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        send(0, 4'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00BB, 26'd0);
        wait_drain(0);
        chk("err_sticky", 64'(err_a), 64'd1);
        chk("err_count", 64'(cnt_a), 64'd2);
        if (popped_a.size() == 2)
            chk("err_addrs", {popped_a[0][63:32], popped_a[1][63:32]}, {32'h0, 32'h4});
        else
            chk("err_n", 64'(popped_a.size()), 64'd2);

        pulse_clear(0);
        rmode[0] = 0;
        send_rand(0, 4'd6);
        send_rand(0, 4'd7);
        iv[0] = 1'b1; clear_a = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; clear_a = 1'b0;
        chk("clr_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("clr_count", 64'(cnt_a), 64'd0);
        rmode[0] = 1;

        for (int r = 0; r < 3; r++) begin
            rmode[1] = 0;
            send_rand(1, 4'($urandom_range(0, 12)));
            send_rand(1, 4'($urandom_range(0, 12)));
            repeat (3) @(negedge clk);
            chk("d2_in_ready", 64'(bus_b.in_ready), 64'd0);
            chk("d2_done_early", 64'(done_b), 64'd0);
            rmode[1] = 1;
            wait_drain(1);
            chk("d2_done", 64'(done_b), 64'd1);
            pulse_clear(1);
            chk("d2_clr", 64'({cnt_b, done_b}), 64'd0);
        end
        send_rand(1, 4'd9);
        chk("d2_base_addr", 64'(bus_b.out_addr), 64'hFFFF_FFFC);
        wait_drain(1);
        pulse_clear(1);

        pulse_clear(0);
        rmode[0] = 2;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) send_rand(0, 4'($urandom_range(13, 15)));
            else send_rand(0, 4'($urandom_range(0, 12)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rmode[0] = 1;
        wait_drain(0);

        rmode[0] = 0;
        send_rand(0, 4'd3);
        send_rand(0, 4'd11);
        #2;
        rst_n = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        chk("arst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("arst_out", {bus_a.out_addr, bus_a.out_word}, 64'd0);
        chk("arst_count", 64'({cnt_a, err_a, bus_a.in_ready}), 64'd0);
        rmode[0] = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
        chk("post_rst_word", {bus_a.out_addr, bus_a.out_word}, {32'h0, 32'h0FFF_FFFF});
        wait_drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
